// File: rtl/wb_lsu_master.sv
// wb_lsu_master
//   Wishbone B4 classic master for the core load/store path. Accepts one
//   byte/half/word load or store at a time, drives byte-lane selects and
//   replicated write data, and returns sign/zero-extended load data.
//   Misalignment, bus error and ack timeout all end in an error response.
//
//   Parameter TIMEOUT : cycles of cyc_o without ack_i/err_i before abort (0 = never)
//
//   Ports
//     clk_i, rst_i          clock, synchronous active-high reset
//     req_*                 core request (valid/ready handshake, we, addr, size,
//                           unsigned, right-aligned write data)
//     resp_*                one-cycle response pulse with error flag and load data
//     cyc_o .. dat_o        Wishbone master outputs (registered)
//     dat_i, ack_i, err_i   Wishbone slave returns
//
//   state | meaning
//   IDLE  | ready for a request
//   BUS   | Wishbone cycle open, waiting for ack/err/timeout
//   RESP  | response pulse on resp_valid_o
module wb_lsu_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);
    localparam int unsigned   CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;

    logic          cyc_d, we_d;
    logic [31:0]   adr_d, dat_d;
    logic [3:0]    sel_d;
    logic          rvalid_d, rerr_d;
    logic [31:0]   rdata_d;

    logic          misaligned;
    logic          timed_out;
    logic [3:0]    lane_sel;
    logic [31:0]   wdata_rep;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_ext;

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign stb_o       = cyc_o;
    assign timed_out   = (TIMEOUT != 0) && (cnt_q == TC);

    assign misaligned = (req_size_i == 2'b11)
                     || ((req_size_i == 2'b01) && req_addr_i[0])
                     || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

    always_comb begin
        lane_sel  = 4'b0000;
        wdata_rep = '0;
        case (req_size_i)
            2'b00: begin
                lane_sel  = 4'b0001 << req_addr_i[1:0];
                wdata_rep = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                lane_sel  = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                lane_sel  = 4'b1111;
                wdata_rep = req_wdata_i;
            end
            default: begin
                lane_sel  = 4'b0000;
                wdata_rep = '0;
            end
        endcase
    end

    // Pick the addressed lane(s) of the returned word, then extend.
    always_comb begin
        ld_byte  = dat_i[7:0];
        case (off_q)
            2'd0:    ld_byte = dat_i[7:0];
            2'd1:    ld_byte = dat_i[15:8];
            2'd2:    ld_byte = dat_i[23:16];
            default: ld_byte = dat_i[31:24];
        endcase
        ld_half  = off_q[1] ? dat_i[31:16] : dat_i[15:0];
        load_ext = dat_i;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: load_ext = dat_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        cyc_d    = cyc_o;
        we_d     = we_o;
        adr_d    = adr_o;
        sel_d    = sel_o;
        dat_d    = dat_o;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    off_d  = req_addr_i[1:0];
                    size_d = req_size_i;
                    uns_d  = req_unsigned_i;
                    if (misaligned) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else begin
                        state_d = BUS;
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                        we_d    = req_we_i;
                        adr_d   = {req_addr_i[31:2], 2'b00};
                        sel_d   = lane_sel;
                        dat_d   = req_we_i ? wdata_rep : '0;
                    end
                end
            end
            BUS: begin
                if (err_i || ack_i || timed_out) begin
                    state_d  = RESP;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    adr_d    = '0;
                    sel_d    = '0;
                    dat_d    = '0;
                    rvalid_d = 1'b1;
                    // err_i wins over ack_i; with neither it was the timeout.
                    rerr_d   = err_i || !ack_i;
                    rdata_d  = (!err_i && ack_i && !we_o) ? load_ext : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            cyc_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= '0;
            sel_o        <= '0;
            dat_o        <= '0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            cyc_o        <= cyc_d;
            we_o         <= we_d;
            adr_o        <= adr_d;
            sel_o        <= sel_d;
            dat_o        <= dat_d;
            resp_valid_o <= rvalid_d;
            resp_err_o   <= rerr_d;
            resp_rdata_o <= rdata_d;
        end
    end
endmodule

// File: tb/tb_wb_lsu_master.sv
module tb_wb_lsu_master;
    localparam int TOUT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [1:0]  req_size_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;

    wb_lsu_master #(.TIMEOUT(TOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          edge_n;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // slave configuration: 0 ack, 1 err, 2 never answer, 3 ack+err together
    int   slv_mode = 0;
    int   slv_wait = 0;
    logic stray = 1'b0;
    logic done = 1'b0;

    logic [7:0] shadow [512];

    function automatic logic [31:0] init_word(input int idx);
        logic [31:0] v;
        v = 32'(idx) * 32'h9E37_79B9;
        return v ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk_i) edge_cnt = edge_cnt + 1;

    // Wishbone slave: word memory, configurable wait states and termination
    logic [31:0] mem [128];
    logic        mem_init = 1'b0;
    int          wcnt = 0;
    always @(negedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] = init_word(i);
            mem_init = 1'b1;
        end
        if (cyc_o && stb_o) begin
            ack_i = 1'b0;
            err_i = 1'b0;
            if (wcnt == slv_wait && slv_mode != 2) begin
                dat_i = mem[adr_o[8:2]];
                if (slv_mode == 0) begin
                    ack_i = 1'b1;
                    if (we_o)
                        for (int k = 0; k < 4; k++)
                            if (sel_o[k]) mem[adr_o[8:2]][8*k +: 8] = dat_o[8*k +: 8];
                end else if (slv_mode == 1) begin
                    err_i = 1'b1;
                end else begin
                    ack_i = 1'b1;
                    err_i = 1'b1;
                end
            end
            wcnt = wcnt + 1;
        end else begin
            ack_i = stray;
            err_i = 1'b0;
            wcnt  = 0;
        end
    end

    // Monitor / scoreboard
    bus_exp_t  cur;
    resp_exp_t re;
    int        cur_len = 0;
    logic      cyc_prev = 1'b0;
    logic      rst_prev = 1'b0;
    int        stray_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) chk("ready_in_reset", 32'(req_ready_o), 0);
        if (rst_i && rst_prev) begin
            chk("rst_cyc", 32'(cyc_o), 0);
            chk("rst_resp_valid", 32'(resp_valid_o), 0);
            chk("rst_we", 32'(we_o), 0);
            chk("rst_adr", adr_o, 0);
            chk("rst_sel", 32'(sel_o), 0);
            chk("rst_dat", dat_o, 0);
            chk("rst_resp_err", 32'(resp_err_o), 0);
            chk("rst_rdata", resp_rdata_o, 0);
        end
        if (!rst_i && rst_prev) chk("ready_after_reset", 32'(req_ready_o), 1);

        if (cyc_o) chk("ready_during_cyc", 32'(req_ready_o), 0);
        if (stb_o !== cyc_o) chk("stb_eq_cyc", 32'(stb_o), 32'(cyc_o));

        if (cyc_o && !cyc_prev) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_cyc", 32'(cyc_o), 0);
            end else begin
                cur = bus_q.pop_front();
                cur_len = 1;
                chk("we_o", 32'(we_o), 32'(cur.we));
                chk("adr_o", adr_o, cur.adr);
                chk("sel_o", 32'(sel_o), 32'(cur.sel));
                chk("dat_o", dat_o, cur.dat);
            end
        end else if (cyc_o && cyc_prev) begin
            cur_len = cur_len + 1;
            if (adr_o !== cur.adr || sel_o !== cur.sel || dat_o !== cur.dat || we_o !== cur.we)
                chk("bus_stable_adr", adr_o, cur.adr);
        end else if (!cyc_o && cyc_prev && !rst_i) begin
            chk("cyc_length", 32'(cur_len), 32'(cur.len));
        end

        if (resp_valid_o) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid_o), 0);
            end else begin
                re = resp_q.pop_front();
                chk("resp_err", 32'(resp_err_o), 32'(re.err));
                chk("resp_rdata", resp_rdata_o, re.rdata);
                chk("resp_latency", 32'(edge_cnt), 32'(re.edge_n));
            end
        end

        if (stray_pend > 0) begin
            chk("stray_no_resp", 32'(resp_valid_o), 0);
            chk("stray_no_cyc", 32'(cyc_o), 0);
            stray_pend = stray_pend - 1;
        end
        if (stray) stray_pend = 2;

        cyc_prev = cyc_o;
        rst_prev = rst_i;

        if (done) begin
            chk("bus_q_drained", 32'(bus_q.size()), 0);
            chk("resp_q_drained", 32'(resp_q.size()), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Reference model: expectations from byte-level memory arithmetic.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input int mode, input int w);
        bus_exp_t  b;
        resp_exp_t r;
        int        nb, off, guard, len;
        bit        mis;
        longint    v;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
        req_valid_i    = 1'b1;
        guard = 0;
        while (!req_ready_o) begin
            @(posedge clk_i); #1;
            guard++;
            if (guard > 50) begin
                $display("FAIL ready_wait: req_ready_o stuck at 0, required 1");
                $fatal(1);
            end
        end
        slv_mode = mode;
        slv_wait = w;
        nb  = 1 << size;
        off = int'(addr % 4);
        mis = (size == 2'b11) || ((addr % nb) != 0);
        len = (mode == 2) ? TOUT : w + 1;
        r.err = 1'b1;
        r.rdata = '0;
        if (mis) begin
            r.edge_n = edge_cnt + 1;
        end else begin
            b.we  = we;
            b.sel = 4'(((1 << nb) - 1) << off);
            for (int k = 0; k < 4; k++)
                b.dat[8*k +: 8] = we ? wdata[8*(k % nb) +: 8] : 8'h00;
            b.adr = addr - 32'(off);
            b.len = len;
            bus_q.push_back(b);
            r.edge_n = edge_cnt + 1 + len;
            if (mode == 0) begin
                r.err = 1'b0;
                if (we) begin
                    for (int i = 0; i < nb; i++) shadow[(addr + 32'(i)) % 512] = wdata[8*i +: 8];
                end else begin
                    v = 0;
                    for (int i = 0; i < nb; i++)
                        v = v + (longint'(shadow[(addr + 32'(i)) % 512]) << (8 * i));
                    if (!uns && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
                    r.rdata = v[31:0];
                end
            end
        end
        resp_q.push_back(r);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int r, sz, mode;
        logic [31:0] a;
        for (int i = 0; i < 128; i++) begin
            logic [31:0] wv;
            wv = init_word(i);
            for (int k = 0; k < 4; k++) shadow[4*i + k] = wv[8*k +: 8];
        end
        idle(3);
        rst_i = 1'b0;
        idle(1);

        // byte store to 0x102, one wait state
        issue(1, 32'h102, 2'b00, 0, 32'h0000_00AB, 0, 1);
        idle(3);
        // word 0x80FF1234 at 0x100, then extended loads of it
        issue(1, 32'h100, 2'b10, 0, 32'h80FF_1234, 0, 0);
        issue(0, 32'h103, 2'b00, 0, 32'h0, 0, 1);
        issue(0, 32'h103, 2'b00, 1, 32'h0, 0, 0);
        issue(0, 32'h102, 2'b01, 0, 32'h0, 0, 2);
        issue(0, 32'h102, 2'b01, 1, 32'h0, 0, 0);
        // misaligned word, illegal size
        issue(0, 32'h102, 2'b10, 0, 32'h0, 0, 0);
        issue(0, 32'h100, 2'b11, 0, 32'h0, 0, 0);
        // timeout, bus error, ack+err together
        issue(0, 32'h100, 2'b10, 0, 32'h0, 2, 0);
        issue(0, 32'h104, 2'b10, 0, 32'h0, 1, 1);
        issue(0, 32'h108, 2'b10, 0, 32'h0, 3, 0);
        // back-to-back store/load
        issue(1, 32'h0, 2'b10, 0, 32'hDEAD_BEEF, 0, 0);
        issue(0, 32'h0, 2'b10, 0, 32'h0, 0, 0);
        idle(4);
        // stray ack while idle
        stray = 1'b1;
        idle(1);
        stray = 1'b0;
        idle(3);
        // reset while the bus cycle is open
        issue(0, 32'h40, 2'b10, 0, 32'h0, 2, 0);
        idle(1);
        rst_i = 1'b1;
        void'(resp_q.pop_back());
        idle(2);
        rst_i = 1'b0;
        idle(1);
        stray = 1'b1;
        idle(1);
        stray = 1'b0;
        idle(3);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            mode = (r < 7) ? 0 : (r == 7) ? 1 : (r == 8) ? 3 : 2;
            sz = $urandom_range(0, 7);
            sz = (sz < 7) ? sz % 3 : 3;
            a = $urandom;
            if ($urandom_range(0, 1) == 1 && sz != 3) a = a & ~((32'd1 << sz) - 1);
            issue(1'($urandom_range(0, 1)), a, 2'(sz), 1'($urandom_range(0, 1)), $urandom,
                  mode, $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end
        idle(20);
        done = 1'b1;
    end
endmodule
